// File: rtl/lifo_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lifo_pkg
// Purpose  : Shared definitions for the multi-channel LIFO. Contains the
//            width helper functions, the operation-decode enum and the
//            full-channel push mode constants.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package lifo_pkg;

    // Values accepted by the OVERWRITE parameter
    localparam int OVW_DROP     = 0;  // push to a full channel is discarded
    localparam int OVW_CIRCULAR = 1;  // push to a full channel replaces the oldest entry

    // State-changing operation applied to the selected channel this cycle
    typedef enum logic [2:0] {
        OP_NONE,
        OP_PUSH,
        OP_POP,
        OP_PEEK,
        OP_REPLACE,
        OP_BYPASS
    } op_e;

    // Top-of-stack pointer width
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Occupancy counter width; must be able to hold the value 'depth'
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    // Channel-select width; at least one bit even for a single channel
    function automatic int ch_width(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lifo_mc_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : lifo_mc_ctrl
// Purpose  : Pointer, occupancy and flag tracking for a single LIFO channel.
//            The parent decodes the operation; this block only applies it
//            when its channel is selected.
// Ports    : clk    - clock
//            reset  - asynchronous active-low reset
//            en     - this channel is the selected one this cycle
//            op     - decoded operation for the selected channel
//            top    - slot holding the current top entry
//            count  - number of valid entries (0..LIFO_DEPTH)
//            empty  - registered, count == 0
//            full   - registered, count == LIFO_DEPTH
// Revision : 1.0 - initial release
// ============================================================================
module lifo_mc_ctrl
    import lifo_pkg::*;
#(
    parameter  int LIFO_DEPTH = 4,
    localparam int PTR_W      = ptr_width(LIFO_DEPTH),
    localparam int CNT_W      = cnt_width(LIFO_DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  op_e              op,
    output logic [PTR_W-1:0] top,
    output logic [CNT_W-1:0] count,
    output logic             empty,
    output logic             full
);

    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(LIFO_DEPTH);

    logic [PTR_W-1:0] top_nxt;
    logic [CNT_W-1:0] count_nxt;

    // Replace, bypass and peek leave pointer and count untouched.
    // A push into a full channel only reaches here in circular mode: the
    // pointer advances onto the oldest slot while the count saturates.
    always_comb begin
        top_nxt   = top;
        count_nxt = count;
        if (en) begin
            case (op)
                OP_PUSH: begin
                    top_nxt = top + PTR_W'(1);
                    if (count != DEPTH_CNT) begin
                        count_nxt = count + CNT_W'(1);
                    end
                end
                OP_POP: begin
                    top_nxt   = top - PTR_W'(1);
                    count_nxt = count - CNT_W'(1);
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            top   <= '0;
            count <= '0;
            empty <= 1'b1;
            full  <= 1'b0;
        end else begin
            top   <= top_nxt;
            count <= count_nxt;
            empty <= (count_nxt == '0);
            full  <= (count_nxt == DEPTH_CNT);
        end
    end

endmodule
`default_nettype wire

// File: rtl/lifo_mc.sv
`default_nettype none
// ============================================================================
// Module   : lifo_mc
// Purpose  : Multi-channel LIFO. NUM_CHANNELS independent stacks share one
//            storage array and one access port selected by ch_sel_i.
//            Supports push, pop, peek, same-cycle push+pop (replace-top /
//            bypass) and optional circular overwrite of full channels.
//            Optional macro LIFO_ERR_EN adds sticky overflow/underflow flags.
// Ports    : clk         - clock
//            reset       - asynchronous active-low reset
//            ch_sel_i    - channel targeted this cycle
//            data_i      - push data
//            push_i      - push request
//            pop_i       - pop request
//            read_lifo_i - peek request
//            empty_o     - per-channel empty flags (registered)
//            full_o      - per-channel full flags (registered)
//            count_o     - occupancy of selected channel (combinational)
//            data_o      - read data (registered)
//            valid_o     - data_o updated by this cycle's pop/peek
//            err_clr_i   - (LIFO_ERR_EN) clear all error flags
//            overflow_o  - (LIFO_ERR_EN) sticky per-channel overflow
//            underflow_o - (LIFO_ERR_EN) sticky per-channel underflow
// Revision : 1.0 - initial release
// ============================================================================
module lifo_mc
    import lifo_pkg::*;
#(
    parameter  int DATA_WIDTH   = 32,
    parameter  int LIFO_DEPTH   = 4,
    parameter  int NUM_CHANNELS = 2,
    parameter  int OVERWRITE    = OVW_DROP,
    localparam int PTR_W        = ptr_width(LIFO_DEPTH),
    localparam int CNT_W        = cnt_width(LIFO_DEPTH),
    localparam int CH_W         = ch_width(NUM_CHANNELS)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [CH_W-1:0]         ch_sel_i,
    input  logic [DATA_WIDTH-1:0]   data_i,
    input  logic                    push_i,
    input  logic                    pop_i,
    input  logic                    read_lifo_i,
`ifdef LIFO_ERR_EN
    input  logic                    err_clr_i,
    output logic [NUM_CHANNELS-1:0] overflow_o,
    output logic [NUM_CHANNELS-1:0] underflow_o,
`endif
    output logic [NUM_CHANNELS-1:0] empty_o,
    output logic [NUM_CHANNELS-1:0] full_o,
    output logic [CNT_W-1:0]        count_o,
    output logic [DATA_WIDTH-1:0]   data_o,
    output logic                    valid_o
);

    localparam int ADDR_W  = CH_W + PTR_W;
    localparam int ENTRIES = NUM_CHANNELS * LIFO_DEPTH;

    // Storage is addressed {channel, slot}; contents are never reset
    logic [DATA_WIDTH-1:0] mem [ENTRIES];

    logic [PTR_W-1:0]        ch_top   [NUM_CHANNELS];
    logic [CNT_W-1:0]        ch_count [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0] ch_en;

    logic                  sel_valid;
    logic [CH_W-1:0]       ch_idx;
    logic [PTR_W-1:0]      sel_top;
    logic                  sel_empty;
    logic                  sel_full;
    op_e                   op;
    logic                  rd_en;
    logic                  wr_en;
    logic [ADDR_W-1:0]     rd_addr;
    logic [ADDR_W-1:0]     wr_addr;
    logic [DATA_WIDTH-1:0] rd_data;

    // Out-of-range selects can only occur when NUM_CHANNELS is not a power of 2
    if (NUM_CHANNELS == (1 << CH_W)) begin : g_sel_full_range
        assign sel_valid = 1'b1;
    end else begin : g_sel_partial_range
        assign sel_valid = (ch_sel_i < CH_W'(NUM_CHANNELS));
    end

    // Clamp so array lookups stay in range; sel_valid gates every effect
    assign ch_idx    = sel_valid ? ch_sel_i : '0;
    assign sel_top   = ch_top[ch_idx];
    assign sel_empty = empty_o[ch_idx];
    assign sel_full  = full_o[ch_idx];
    assign count_o   = sel_valid ? ch_count[ch_idx] : '0;

    for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_ch
        assign ch_en[i] = sel_valid && (ch_idx == CH_W'(i));

        lifo_mc_ctrl #(
            .LIFO_DEPTH (LIFO_DEPTH)
        ) u_ctrl (
            .clk   (clk),
            .reset (reset),
            .en    (ch_en[i]),
            .op    (op),
            .top   (ch_top[i]),
            .count (ch_count[i]),
            .empty (empty_o[i]),
            .full  (full_o[i])
        );
    end

    // Pop wins over peek. A peek alongside an accepted push still returns
    // the pre-push top, so rd_en is tracked apart from the state-changing op.
    always_comb begin
        op    = OP_NONE;
        rd_en = 1'b0;
        if (sel_valid) begin
            if (pop_i) begin
                if (push_i) begin
                    op = sel_empty ? OP_BYPASS : OP_REPLACE;
                end else if (!sel_empty) begin
                    op = OP_POP;
                end
                rd_en = push_i || !sel_empty;
            end else begin
                if (push_i && (!sel_full || (OVERWRITE == OVW_CIRCULAR))) begin
                    op = OP_PUSH;
                end else if (read_lifo_i && !sel_empty) begin
                    op = OP_PEEK;
                end
                rd_en = read_lifo_i && !sel_empty;
            end
        end
    end

    assign rd_addr = {ch_idx, sel_top};
    assign wr_addr = (op == OP_PUSH) ? {ch_idx, sel_top + PTR_W'(1)} : rd_addr;
    assign wr_en   = (op == OP_PUSH) || (op == OP_REPLACE);
    assign rd_data = (op == OP_BYPASS) ? data_i : mem[rd_addr];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= data_i;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_o  <= '0;
            valid_o <= 1'b0;
        end else begin
            valid_o <= rd_en;
            if (rd_en) begin
                data_o <= rd_data;
            end
        end
    end

`ifdef LIFO_ERR_EN
    logic ovf_evt;
    logic udf_evt;

    // A replace (push+pop) is not an overflow; a push alongside a pop or
    // peek on an empty channel is not an underflow.
    assign ovf_evt = push_i && !pop_i && sel_full;
    assign udf_evt = (pop_i || read_lifo_i) && !push_i && sel_empty;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow_o  <= '0;
            underflow_o <= '0;
        end else begin
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                if (ch_en[i] && ovf_evt) begin
                    overflow_o[i] <= 1'b1;
                end else if (err_clr_i) begin
                    overflow_o[i] <= 1'b0;
                end
                if (ch_en[i] && udf_evt) begin
                    underflow_o[i] <= 1'b1;
                end else if (err_clr_i) begin
                    underflow_o[i] <= 1'b0;
                end
            end
        end
    end
`endif

endmodule
`default_nettype wire
